// File: rtl/level_pkg.sv
// Shared level definitions for the difficulty-selection path: level codes,
// per-level object counts and speed shifts, error codes and the pacer FSM type.
package level_pkg;

   localparam logic [1:0] LVL_INVALID = 2'b00;
   localparam logic [1:0] LVL_EASY    = 2'b01;
   localparam logic [1:0] LVL_NORMAL  = 2'b10;
   localparam logic [1:0] LVL_HARD    = 2'b11;

   localparam int unsigned COUNT_EASY   = 8;
   localparam int unsigned COUNT_NORMAL = 12;
   localparam int unsigned COUNT_HARD   = 16;

   // Spawn period is BASE_PERIOD shifted right by these amounts.
   localparam logic [1:0] SHIFT_EASY   = 2'd0;
   localparam logic [1:0] SHIFT_NORMAL = 2'd1;
   localparam logic [1:0] SHIFT_HARD   = 2'd2;

   localparam logic [3:0] ERR_OK        = 4'd0;
   localparam logic [3:0] ERR_BAD_LEVEL = 4'd1;
   localparam logic [3:0] ERR_ABORT     = 4'd2;

   typedef enum logic {StIdle, StRun} pacer_state_e;

   // Index of the final spawn of a run (object count minus one).
   function automatic logic [3:0] level_last_idx(input logic [1:0] code);
      logic [3:0] idx;
      case (code)
         LVL_EASY:   idx = 4'(COUNT_EASY - 1);
         LVL_NORMAL: idx = 4'(COUNT_NORMAL - 1);
         LVL_HARD:   idx = 4'(COUNT_HARD - 1);
         default:    idx = 4'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] level_shift(input logic [1:0] code);
      logic [1:0] sh;
      case (code)
         LVL_NORMAL: sh = SHIFT_NORMAL;
         LVL_HARD:   sh = SHIFT_HARD;
         default:    sh = SHIFT_EASY;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter with auto-reload. tick is registered and is high in
// exactly the cycles where the count sits at zero while the counter is live.
module tick_divider #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tick
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] reload_q, reload_d;
   logic         tick_q, tick_d;

   // Next count: clear beats load beats decrement; load also captures the reload value.
   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      tick_d   = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d    = load_val;
         reload_d = load_val;
         tick_d   = (load_val == '0);
      end else if (en) begin
         if (cnt_q == '0) begin
            cnt_d = reload_q;
         end else begin
            cnt_d = cnt_q - W'(1);
         end
         tick_d = (cnt_d == '0);
      end
   end

   // Counter, reload and tick registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         reload_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         tick_q   <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/level_pacer.sv
// Accepts a level code over valid/ready, then emits one spawn pulse per object
// at the level's rate until the count is exhausted or the run is aborted.
module level_pacer
   import level_pkg::*;
#(
   parameter int unsigned BASE_PERIOD = 50_000_000,
   parameter int unsigned CNT_W       = $clog2(BASE_PERIOD)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       level_valid,
   input  logic [1:0] level_code,
   output logic       level_ready,
   input  logic       abort,
   output logic       spawn_pulse,
   output logic [3:0] spawn_idx,
   output logic       busy,
   output logic       done,
   output logic [3:0] error_code
);

   pacer_state_e state_q, state_d;
   logic         busy_q, busy_d;
   logic         ready_q, ready_d;
   logic         done_q, done_d;
   logic [3:0]   idx_q, idx_d;
   logic [3:0]   err_q, err_d;
   logic [3:0]   last_idx_q, last_idx_d;

   logic             div_load, div_clr, div_en, tick;
   logic [CNT_W-1:0] period_m1;

   // Interval minus one for the presented code; BASE_PERIOD is a multiple of 4 so no rounding.
   always_comb begin
      period_m1 = CNT_W'((BASE_PERIOD >> level_shift(level_code)) - 1);
   end

   assign div_en = (state_q == StRun);

   tick_divider #(
      .W (CNT_W)
   ) u_tick_divider (
      .clk      (clk),
      .rst      (rst),
      .clr      (div_clr),
      .load     (div_load),
      .load_val (period_m1),
      .en       (div_en),
      .tick     (tick)
   );

   // FSM next state, handshake and spawn counter.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      idx_d      = idx_q;
      err_d      = err_q;
      last_idx_d = last_idx_q;
      div_load   = 1'b0;
      div_clr    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (level_valid && ready_q) begin
               if (level_code == LVL_INVALID) begin
                  err_d = ERR_BAD_LEVEL;
               end else begin
                  state_d    = StRun;
                  busy_d     = 1'b1;
                  ready_d    = 1'b0;
                  idx_d      = 4'd0;
                  err_d      = ERR_OK;
                  last_idx_d = level_last_idx(level_code);
                  div_load   = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort) begin
               // Clearing the divider also swallows a spawn due next cycle.
               state_d = StIdle;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               idx_d   = 4'd0;
               err_d   = ERR_ABORT;
               div_clr = 1'b1;
            end else if (tick) begin
               if (idx_q == last_idx_q) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
                  idx_d   = 4'd0;
                  div_clr = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         idx_q      <= 4'd0;
         err_q      <= ERR_OK;
         last_idx_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         last_idx_q <= last_idx_d;
      end
   end

   assign level_ready = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign spawn_idx   = idx_q;
   assign error_code  = err_q;
   assign spawn_pulse = tick;

endmodule

// File: tb/tb_level_pacer.sv
module tb_level_pacer;

   localparam int unsigned BASE = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       level_valid = 1'b0;
   logic [1:0] level_code = 2'b00;
   logic       abort = 1'b0;
   logic       level_ready, spawn_pulse, busy, done;
   logic [3:0] spawn_idx, error_code;

   level_pacer #(
      .BASE_PERIOD (BASE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .level_valid (level_valid),
      .level_code  (level_code),
      .level_ready (level_ready),
      .abort       (abort),
      .spawn_pulse (spawn_pulse),
      .spawn_idx   (spawn_idx),
      .busy        (busy),
      .done        (done),
      .error_code  (error_code)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: a run is described by its start cycle, period and count;
   // expected outputs follow from elapsed-cycle arithmetic.
   bit         m_active = 1'b0;
   int         m_t0 = 0;
   int         m_p = 1;
   int         m_n = 0;
   logic [3:0] m_err = 4'd0;
   bit         m_done = 1'b0;
   bit         m_reset = 1'b0;

   typedef struct {
      logic [1:0] code;
      int         abort_at;
      int         n_pulses;
      int         first_at;
      int         last_at;
      int         done_at;
      logic [3:0] err;
   } scen_t;

   scen_t scen [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [1:0] code, input bit a);
      int c;
      c = cyc;
      cyc++;
      m_done  = 1'b0;
      m_reset = 1'b0;
      if (r) begin
         m_active = 1'b0;
         m_err    = 4'd0;
         m_reset  = 1'b1;
      end else if (m_active) begin
         if (a) begin
            m_active = 1'b0;
            m_err    = 4'd2;
         end else if (c - m_t0 == m_n * m_p) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end else if (v) begin
         if (code == 2'b00) begin
            m_err = 4'd1;
         end else begin
            m_t0     = c;
            m_p      = int'(BASE) / (1 << (int'(code) - 1));
            m_n      = 4 + 4 * int'(code);
            m_err    = 4'd0;
            m_active = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      int  e;
      bit  exp_pulse;
      e         = cyc - m_t0;
      exp_pulse = m_active && (e % m_p == 0);
      chk("level_ready", level_ready, !m_active);
      chk("busy", busy, m_active);
      chk("spawn_pulse", spawn_pulse, exp_pulse);
      chk("done", done, m_done);
      chk("error_code", error_code, m_err);
      if (exp_pulse) chk("spawn_idx", spawn_idx, e / m_p - 1);
      if (m_reset) chk("spawn_idx_reset", spawn_idx, 0);
   endtask

   // Drive one cycle of inputs, cross the edge, then compare against the model.
   task automatic step(input bit r, input bit v, input logic [1:0] code, input bit a);
      rst         = r;
      level_valid = v;
      level_code  = code;
      abort       = a;
      @(posedge clk);
      #1;
      model_step(r, v, code, a);
      check_outputs();
   endtask

   task automatic run_scen(input int i);
      int np, first, last, done_at;
      np = 0; first = 0; last = 0; done_at = 0;
      step(1'b0, 1'b1, scen[i].code, 1'b0);
      for (int off = 1; off <= 100; off++) begin
         if (spawn_pulse) begin
            np++;
            if (first == 0) first = off;
            last = off;
         end
         if (done) done_at = off;
         step(1'b0, 1'b0, 2'b00, off == scen[i].abort_at);
      end
      chk("scen_pulses", np, scen[i].n_pulses);
      chk("scen_first", first, scen[i].first_at);
      chk("scen_last", last, scen[i].last_at);
      chk("scen_done_at", done_at, scen[i].done_at);
      chk("scen_err", error_code, scen[i].err);
   endtask

   initial begin
      int first_hard, done_at, np, k;

      // code, abort_at (0 = none), pulses, first, last, done offset, error
      scen[0] = '{2'b01, 0, 8, 8, 64, 65, 4'd0};
      scen[1] = '{2'b10, 0, 12, 4, 48, 49, 4'd0};
      scen[2] = '{2'b11, 0, 16, 2, 32, 33, 4'd0};
      scen[3] = '{2'b00, 0, 0, 0, 0, 0, 4'd1};
      scen[4] = '{2'b10, 12, 3, 4, 12, 0, 4'd2};
      scen[5] = '{2'b11, 1, 0, 0, 0, 0, 4'd2};
      scen[6] = '{2'b11, 32, 16, 2, 32, 0, 4'd2};
      scen[7] = '{2'b01, 8, 1, 8, 8, 0, 4'd2};

      step(1'b1, 1'b0, 2'b00, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      step(1'b0, 1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 8; i++) run_scen(i);

      // Held request for a hard run during an easy run: accepted only as the easy run ends.
      first_hard = 0; done_at = 0;
      step(1'b0, 1'b1, 2'b01, 1'b0);
      for (int off = 1; off <= 80; off++) begin
         if (done && done_at == 0) done_at = off;
         if (spawn_pulse && off > 65 && first_hard == 0) first_hard = off;
         step(1'b0, 1'b1, 2'b11, 1'b0);
      end
      chk("b2b_done_at", done_at, 65);
      chk("b2b_hard_first", first_hard, 67);
      repeat (30) step(1'b0, 1'b0, 2'b00, 1'b0);

      // Reset in the middle of a run, then a normal easy run.
      k = int'($urandom_range(2, 60));
      step(1'b0, 1'b1, 2'b01, 1'b0);
      repeat (k) step(1'b0, 1'b0, 2'b00, 1'b0);
      step(1'b1, 1'b0, 2'b00, 1'b0);
      chk("rst_ready", level_ready, 1);
      chk("rst_busy", busy, 0);
      step(1'b0, 1'b1, 2'b01, 1'b0);
      np = 0; done_at = 0;
      for (int off = 1; off <= 70; off++) begin
         if (spawn_pulse) np++;
         if (done) done_at = off;
         step(1'b0, 1'b0, 2'b00, 1'b0);
      end
      chk("post_rst_pulses", np, 8);
      chk("post_rst_done_at", done_at, 65);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 300) == 0, ($urandom % 3) == 0, 2'($urandom), ($urandom % 40) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/level_pacer.md
# level_pacer

Consumer side of the difficulty-selection interface. Accepts a validated level code through a valid/ready handshake. Latches it and derives the spawn interval and object count: easy ×1 speed/8 objects, normal ×2/12, hard ×4/16. It then emits one spawn pulse per object at the selected rate until the count is exhausted or the run is aborted. It sits between the level-select front end and the game manager/object spawner.

## Interface
- BASE_PERIOD, 50_000_000, easy-level spawn interval in clk cycles; must be a multiple of 4 and ≥ 4
- CNT_W, $clog2(BASE_PERIOD), interval counter width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- level_valid  in  1  level_code is presented
- level_code  in  2  01 easy, 10 normal, 11 hard, 00 invalid
- level_ready  out  1  block can accept a level (IDLE)
- abort  in  1  terminate the current run
- spawn_pulse  out  1  single-cycle spawn strobe
- spawn_idx  out  4  index of the current spawn, 0..count-1; valid with spawn_pulse
- busy  out  1  run in progress
- done  out  1  single-cycle strobe after the last spawn of a completed run
- error_code  out  4  0 ok, 1 invalid level, 2 aborted; sticky

## Operation
- States: IDLE, RUN.
- IDLE:
  - level_ready=1.
  - The handshake fires on level_valid & level_ready.
- Valid code accepted:
  - Latch the count (8/12/16) and the period (BASE_PERIOD, /2, /4).
  - Load the interval counter with period-1, clear the spawn counter, set error_code=0, go to RUN.
- Code 00 accepted: set error_code=1 and stay in IDLE. No pulses, no done.
- RUN:
  - level_ready=0. level_valid is ignored; upstream holds it.
  - Interval counter decrements each cycle. At 0 it asserts spawn_pulse with spawn_idx = spawn counter, reloads period-1, and increments the spawn counter.
  - After the pulse with spawn_idx = count-1, the next cycle is IDLE with done=1.
- abort:
  - abort=1 in a RUN cycle: the next cycle is IDLE with error_code=2, and spawn_pulse is suppressed in that cycle even if it was due. No done.
  - abort in IDLE has no effect.
- All outputs are registered.
- Reset values: state IDLE, level_ready=1, spawn_pulse=0, spawn_idx=0, busy=0, done=0, error_code=0, counters 0.
- rst mid-run returns all outputs to reset values on the next cycle. No done and no error is reported.
- Period arithmetic: shift right of BASE_PERIOD by (level-1) bits, in CNT_W bits. No rounding, because BASE_PERIOD is a multiple of 4.

## Timing
- Handshake in cycle t: busy=1 and level_ready=0 from cycle t+1.
- Spawn k (k=1..N) has spawn_pulse=1 in cycle t+k·period.
- done=1, busy=0 and level_ready=1 in cycle t+N·period+1.
- A new level may be accepted in that same cycle, so back-to-back runs are separated by ≥1 IDLE cycle.
- error_code updates in the cycle after the causing event and holds until the next accepted code or rst.

## Structure
- Package level_pkg:
  - level code constants (LVL_EASY=2'b01, LVL_NORMAL=2'b10, LVL_HARD=2'b11)
  - count table 8/12/16
  - speed shift amounts 0/1/2
  - error codes ERR_OK=0, ERR_BAD_LEVEL=1, ERR_ABORT=2
  - shared with level_select and the game manager
- Sub-module tick_divider: loadable down-counter with load, enable, a tick output at zero and auto-reload.
- The FSM, spawn counter and handshake stay in level_pacer.

## Test plan
- BASE_PERIOD=8, level 01 accepted at t → spawn_pulse at t+8, t+16 … t+64 with spawn_idx 0..7; done and level_ready=1 at t+65; error_code=0.
- Level 11 at t → 16 pulses every 2 cycles, first at t+2, last (spawn_idx=15) at t+32; done at t+33.
- Level 00 with valid → error_code=1 next cycle, busy stays 0, no spawn_pulse and no done for 100 cycles, level_ready stays 1.
- Level 10, abort asserted in the cycle of the 3rd pulse's reload (t+12) → busy=0 and error_code=2 at t+13, no further pulses, done never asserted.
- level_valid held high with code 11 throughout a level-01 run → ignored until t+65; handshake fires at t+65 and the hard run starts with its first pulse at t+67.
- rst asserted mid-run at an arbitrary cycle → all outputs at reset values the next cycle; a new level-01 request after rst release is accepted and runs normally.
